present_decrypt: RTL
====================

Name: present_decrypt

Overview:
Iterative PRESENT-80 block decryptor; inverse of PRESENT_ENCRYPT, with the same idat/key/load/odat/done interface style.
- Processes one 64-bit ciphertext under an 80-bit key.
- Computes one round per clock: a forward key-schedule phase reaches K32, then 31 inverse rounds run while the key schedule is walked back.
- Sits beside the encryptor in the cipher datapath.
- Output matches the PRESENT-80 reference plaintext.

Parameters:
ROUNDS, 31, number of PRESENT rounds (fixed by algorithm; not intended to be overridden)

Ports:
clk      input   1   rising-edge clock
reset_n  input   1   asynchronous active-low reset
load     input   1   start strobe; sampled on clk rising edge
idat     input   64  ciphertext; sampled when load=1
key      input   80  cipher key; sampled when load=1
odat     output  64  recovered plaintext; valid while done=1
done     output  1   result valid; level signal
busy     output  1   high from accepted load until result is written

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state -> IDLE; odat=0, done=0, busy=0.
  - Internal state/key/round registers cleared.
  - Reset mid-operation aborts with no partial result.
- States: IDLE, KEYEXP, DEC, FIN.
- load=1 at any edge, in any state:
  - Captures idat into the state register and key into the key register; round counter r=1.
  - Next state KEYEXP; busy=1, done=0.
  - Load while busy restarts (abort and reload); odat keeps its old value but done drops.
- KEYEXP, 31 cycles, r=1..31, forward update each cycle:
  - k = k rotated left 61.
  - k[79:76] = S(k[79:76]).
  - k[19:15] ^= r[4:0].
  - After r=31 the key register holds K32; set r=31; go to DEC.
- DEC, 31 cycles, r=31 down to 1; key register holds K(r+1) at cycle entry:
  - state <= invS(invP(state ^ key)), with invS applied to all 16 nibbles.
  - Inverse key update to K(r), with r read before decrement:
    - k[19:15] ^= r.
    - k[79:76] = invS(k[79:76]).
    - k = k rotated right 61.
  - After r=1, go to FIN.
- FIN, 1 cycle: odat <= state ^ key (key = K1); done <= 1; busy <= 0; go to IDLE.
- Latency: load captured at edge N; done and odat are visible after edge N+63.
- done stays high, and odat holds, until the next accepted load or reset.
- IDLE with load=0: all registers hold.
- Round counter is 5 bits and never wraps: KEYEXP exits at 31 and DEC exits at 1.
- pLayer: bit i moves to (16*i) mod 63 for i<63; bit 63 is fixed. invP is the inverse mapping.
- S-box, nibble index: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- invS: 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A.
- All arithmetic is bitwise XOR and permutation; there are no carries.

Decomposition:
- Package present_pkg, shared with PRESENT_ENCRYPT:
  - SBOX and INV_SBOX nibble tables.
  - p_layer/inv_p_layer functions.
  - ROUNDS=31 constant.
  - Key-width (80) and block-width (64) localparams.
  - State enum encoding.
- Sub-module present_dec_round, purely combinational:
  - Inputs: state, key, r.
  - Outputs: next state and previous round key.
  - Reused unchanged in any future unrolled variant.
- FSM and registers stay in present_decrypt.

Test Plan:
- Key 0, idat 5579C1387B228445, load one cycle -> done rises exactly 63 cycles later; odat=0000000000000000; busy high throughout.
- Key FFFFFFFFFFFFFFFFFFFF, idat E72C46C0F5945049 -> odat=0000000000000000.
- Key 0, idat A112FFC72F68417B -> odat=FFFFFFFFFFFFFFFF.
- Key all-F, idat 3333DCD3213210D2 -> odat=FFFFFFFFFFFFFFFF.
  - Then loopback: 20 random idat/key pairs through PRESENT_ENCRYPT then present_decrypt -> output equals original plaintext.
- Restart and reset mid-operation:
  - Assert load with the third vector at cycle 20 of a decryption -> done=0 until 63 cycles after the second load; odat=FFFFFFFFFFFFFFFF.
  - Separately, pulse reset_n low mid-DEC -> odat=0, done=0, busy=0 immediately; no done until a new load.
- Hold behaviour: after done, keep load=0 for 100 cycles -> odat and done stable. Back-to-back loads on consecutive cycles -> only the last is processed.

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, S-box tables, bit permutations and key schedule step.
// Latency: n/a (package of constants and combinational functions).
// Backpressure: n/a.
// Contents: SBOX/INV_SBOX, p_layer/inv_p_layer, key_fwd, ROUNDS, KEY_W, BLK_W, fsm_e.
package present_pkg;

   localparam int KEY_W = 80;
   localparam int BLK_W = 64;
   localparam logic [4:0] ROUNDS = 5'd31;

   typedef enum logic [1:0] {IDLE, KEYEXP, DEC, FIN} fsm_e;

   // Nibble tables packed with entry x at bits [4x+3:4x].
   localparam logic [63:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      return INV_SBOX[{x, 2'b00} +: 4];
   endfunction

   // Bit i moves to (16*i) mod 63; bit 63 stays in place.
   function automatic logic [63:0] p_layer(input logic [63:0] s);
      logic [63:0] o;
      o = '0;
      for (int i = 0; i < 63; i++) o[(16 * i) % 63] = s[i];
      o[63] = s[63];
      return o;
   endfunction

   function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
      logic [63:0] o;
      o = '0;
      for (int i = 0; i < 63; i++) o[i] = s[(16 * i) % 63];
      o[63] = s[63];
      return o;
   endfunction

   // Forward key schedule: K(r) -> K(r+1).
   function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] r);
      logic [79:0] o;
      o = {k[18:0], k[79:19]};          // rotate left 61
      o[79:76] = sbox(o[79:76]);
      o[19:15] = o[19:15] ^ r;
      return o;
   endfunction

endpackage

// File: rtl/present_dec_round.sv
// One PRESENT-80 inverse round plus one backward key-schedule step.
// Latency: combinational.
// Backpressure: none.
// Ports: state/key = current block and K(r+1); r = round index; nstate = invS(invP(state^rk)); pkey = K(r).
module present_dec_round
   import present_pkg::*;
(
   input  logic [BLK_W-1:0] state,
   input  logic [KEY_W-1:0] key,
   input  logic [4:0]       r,
   output logic [BLK_W-1:0] nstate,
   output logic [KEY_W-1:0] pkey
);

   logic [BLK_W-1:0] mixed;
   logic [KEY_W-1:0] kx;

   always_comb begin
      mixed  = inv_p_layer(state ^ key[79:16]);
      nstate = '0;
      for (int n = 0; n < 16; n++) nstate[4*n +: 4] = inv_sbox(mixed[4*n +: 4]);

      // Undo the forward step in reverse order: counter XOR, S-box, rotation.
      kx        = key;
      kx[19:15] = kx[19:15] ^ r;
      kx[79:76] = inv_sbox(kx[79:76]);
      pkey      = {kx[60:0], kx[79:61]};  // rotate right 61
   end

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryptor: 31 forward key steps, 31 inverse rounds, final whitening.
// Latency: load at edge N -> odat/done valid after edge N+63.
// Backpressure: none; load in any state aborts and restarts, done holds until next load/reset.
// Ports: clk, reset_n (async low), load/idat/key in; odat/done/busy out.
module present_decrypt
   import present_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [BLK_W-1:0] idat,
   input  logic [KEY_W-1:0] key,
   output logic [BLK_W-1:0] odat,
   output logic             done,
   output logic             busy
);

   fsm_e             fsm;
   logic [BLK_W-1:0] blk;
   logic [KEY_W-1:0] kreg;
   logic [4:0]       r;
   logic [BLK_W-1:0] blk_nxt;
   logic [KEY_W-1:0] key_prev;

   present_dec_round u_round (
      .state  (blk),
      .key    (kreg),
      .r      (r),
      .nstate (blk_nxt),
      .pkey   (key_prev)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm  <= IDLE;
         blk  <= '0;
         kreg <= '0;
         r    <= '0;
         odat <= '0;
         done <= 1'b0;
         busy <= 1'b0;
      end else if (load) begin
         // Restart from any state; odat keeps its last value, done drops.
         fsm  <= KEYEXP;
         blk  <= idat;
         kreg <= key;
         r    <= 5'd1;
         done <= 1'b0;
         busy <= 1'b1;
      end else begin
         case (fsm)
            KEYEXP: begin
               kreg <= key_fwd(kreg, r);
               // r stays at 31 so DEC starts with the right counter value.
               if (r == ROUNDS) fsm <= DEC;
               else             r   <= r + 5'd1;
            end
            DEC: begin
               blk  <= blk_nxt;
               kreg <= key_prev;
               if (r == 5'd1) fsm <= FIN;
               else           r   <= r - 5'd1;
            end
            FIN: begin
               odat <= blk ^ kreg[79:16];
               done <= 1'b1;
               busy <= 1'b0;
               fsm  <= IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule
